bin_to_bcd_display: RTL and testbench

Sequential binary-to-BCD converter that feeds the 8-digit seven-segment display driver. Accepts an unsigned binary value on a start pulse, runs a shift-and-add-3 (double-dabble) conversion at one bit per clock, and presents a registered 32-bit packed-BCD word. Each nibble of that word is one display digit, with digit 0 in bits [3:0]. The output holds steady between conversions so the display driver can scan it freely.

---
 rtl/bin_to_bcd_display.sv | 135 +++++++++++++
 tb/tb_bin_to_bcd_display.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_display
// Brief    : Sequential double-dabble binary-to-BCD converter that feeds an
//            8-digit display. Optional leading-zero blanking is enabled by
//            defining LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_display #(
    parameter int         IN_WIDTH   = 27,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] bin_in,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [31:0]         encoded
);

    localparam int          c_CNT_W     = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [31:0] c_MAX_DEC   = 32'd99_999_999;
    localparam logic [31:0] c_SATURATED = 32'h9999_9999;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [IN_WIDTH-1:0]  r_bin;
    logic [31:0]          r_bcd;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ovf_pend;
    logic                 r_done;
    logic                 r_overflow;
    logic [31:0]          r_encoded;
    logic [31:0]          w_bin_ext;
    logic [31:0]          w_bcd_adj;
    logic [7:0]           w_blank;
    logic [31:0]          w_final;

    assign w_bin_ext = {{(32-IN_WIDTH){1'b0}}, bin_in};

    generate
        for (genvar i = 0; i < 8; i++) begin : g_digit
            assign w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                                         (r_bcd[4*i +: 4] + 4'd3) : r_bcd[4*i +: 4];
            assign w_final[4*i +: 4]   = w_blank[i] ? BLANK_CODE : r_bcd[4*i +: 4];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero while it and every digit above it are zero.
    always_comb begin
        logic w_lead;
        w_blank = '0;
        w_lead  = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            w_lead     = w_lead && (r_bcd[4*i +: 4] == 4'd0);
            w_blank[i] = w_lead;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == '0) w_state_next = S_FINISH;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_encoded  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin      <= bin_in;
                        r_bcd      <= '0;
                        r_cnt      <= c_CNT_W'(IN_WIDTH - 1);
                        r_overflow <= 1'b0;
                        r_ovf_pend <= (w_bin_ext > c_MAX_DEC);
                    end
                end
                S_SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[30:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt - 1'b1;
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    if (r_ovf_pend) begin
                        r_encoded  <= c_SATURATED;
                        r_overflow <= 1'b1;
                    end else begin
                        r_encoded  <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign overflow = r_overflow;
    assign encoded  = r_encoded;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_display.sv
`default_nettype none
// Testbench for bin_to_bcd_display: directed cases plus a random sweep,
// checked by a queue-based scoreboard against a decimal reference model.
module tb_bin_to_bcd_display;

    localparam int W = 27;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  bin_in;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [31:0]   encoded;

    bin_to_bcd_display #(.IN_WIDTH(W), .BLANK_CODE(4'hF)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .encoded  (encoded)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] enc;
        logic        ovf;
        int unsigned e0;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits by division; digit i>0 is a leading zero iff v < 10^i.
    function automatic exp_t model(input int unsigned v, input int unsigned e0);
        exp_t        r;
        int unsigned p;
        r.e0 = e0;
        r.enc = '0;
        r.ovf = 1'b0;
        p = 1;
        if (v > 99_999_999) begin
            r.enc = 32'h9999_9999;
            r.ovf = 1'b1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                r.enc[4*i +: 4] = 4'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
                if (i > 0 && v < p) r.enc[4*i +: 4] = 4'hF;
`endif
                p = p * 10;
            end
        end
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    logic prev_done = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (done) begin
            check("done_width", {63'd0, prev_done}, 64'd0);
            check("busy_low_at_done", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 encoded=%0h expected no done", encoded);
            end else begin
                mon_e = sb.pop_front();
                check("encoded", {32'd0, encoded}, {32'd0, mon_e.enc});
                check("overflow", {63'd0, overflow}, {63'd0, mon_e.ovf});
                check("latency", 64'(cyc - mon_e.e0), 64'd28);
            end
        end
        prev_done = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int unsigned v);
        start  = 1'b1;
        bin_in = W'(v);
        tick();
        start  = 1'b0;
        sb.push_back(model(v, cyc));
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: got no done within 40 cycles expected done at latency 28");
            sb.delete();
        end
    endtask

    task automatic convert(input int unsigned v);
        launch(v);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned e0;
        reset  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_encoded", {32'd0, encoded}, 64'd0);
        tick();
        reset = 1'b1;
        tick();

        convert(12_345_678);
        convert(0);
        convert(99_999_999);
        convert(100_000_000);
        repeat (3) tick();
        check("overflow_sticky", {63'd0, overflow}, 64'd1);
        check("encoded_hold", {32'd0, encoded}, 64'h9999_9999);
        convert(7);
        convert((1 << W) - 1);
        convert(42);

        // Starts while busy (edges 5 and 27) and in FINISH (edge 28) are ignored.
        launch(1000);
        e0 = cyc;
        bin_in = W'(555);
        for (int k = 1; k <= 28; k++) begin
            start = (k == 5 || k == 27 || k == 28);
            tick();
        end
        start = 1'b0;
        check("done_cycle_after_ignored", {63'd0, done}, 64'd1);
        check("ignored_start_cycle", 64'(cyc - e0), 64'd28);
        launch(555);
        wait_idle();

        // Asynchronous reset mid-conversion.
        launch(31_415_926);
        repeat (9) tick();
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        check("async_rst_overflow", {63'd0, overflow}, 64'd0);
        check("async_rst_encoded", {32'd0, encoded}, 64'd0);
        sb.delete();
        repeat (2) tick();
        reset = 1'b1;
        repeat (30) tick();
        convert(9_876_543);

        for (int i = 0; i < 1000; i++) begin
            convert($urandom_range(99_999_999, 0));
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
